// File: rtl/delay_timer_pkg.sv
// Shared types and defaults for the programmable delay timer.
package delay_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ONE_SHOT  = 2'b00,
        RETRIG    = 2'b01,
        ON_DELAY  = 2'b10,
        OFF_DELAY = 2'b11
    } mode_e;

endpackage

// File: rtl/trig_edge_det.sv
// Trigger edge detector: optional 2-flop synchronizer (TRIG_SYNC_EN), then the trig_q register.
// Provides the conditioned trigger level together with single-cycle rise/fall strobes.
module trig_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_trigger,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic w_trig;
    logic r_trig_q;

`ifdef TRIG_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_trigger};
        end
    end

    assign w_trig = r_sync[1];
`else
    assign w_trig = i_trigger;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trig_q <= 1'b0;
        end else begin
            r_trig_q <= w_trig;
        end
    end

    assign o_level = w_trig;
    assign o_rise  = w_trig & ~r_trig_q;
    assign o_fall  = ~w_trig & r_trig_q;

endmodule

// File: rtl/prog_delay_timer.sv
// Programmable delay timer: one-shot, retriggerable one-shot, on-delay and off-delay modes.
// Optional build macro TRIG_SYNC_EN adds a 2-flop trigger synchronizer (+2 cycles latency).
module prog_delay_timer
    import delay_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Wb,
    input  logic             mode_a,
    input  logic             mode_b,
    input  logic             trigger,
    output logic             delay_out
);

    mode_e            w_mode;
    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_expire;
    logic             w_wb_zero;
    logic [WIDTH-1:0] w_load;

    mode_e            r_mode_q;
    logic [WIDTH-1:0] r_cnt;
    logic             r_busy;
    logic             r_out;

    trig_edge_det u_edge (
        .clk       (clk),
        .reset     (reset),
        .i_trigger (trigger),
        .o_level   (w_level),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign w_mode    = mode_e'({mode_a, mode_b});
    assign w_wb_zero = (Wb == '0);
    assign w_load    = Wb - 1'b1;
    // r_busy separates "counting" from r_cnt==0, so a final cycle at count 0 is still live
    assign w_expire  = r_busy && (r_cnt == '0);
    assign delay_out = r_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_mode_q <= w_mode;
        end else if (w_mode != r_mode_q) begin
            r_out    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_mode_q <= w_mode;
        end else begin
            if (r_busy && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            case (r_mode_q)
                ONE_SHOT: begin
                    if (r_busy) begin
                        if (w_expire) begin
                            r_out  <= 1'b0;
                            r_busy <= 1'b0;
                        end
                    end else if (w_rise && !w_wb_zero) begin
                        r_out  <= 1'b1;
                        r_busy <= 1'b1;
                        r_cnt  <= w_load;
                    end
                end
                RETRIG: begin
                    // a rise beats a coincident expiry, so the pulse never drops on reload
                    if (w_rise) begin
                        r_out  <= !w_wb_zero;
                        r_busy <= !w_wb_zero;
                        r_cnt  <= w_wb_zero ? '0 : w_load;
                    end else if (w_expire) begin
                        r_out  <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                ON_DELAY: begin
                    if (w_fall) begin
                        r_out  <= 1'b0;
                        r_busy <= 1'b0;
                        r_cnt  <= '0;
                    end else if (w_rise) begin
                        if (w_wb_zero) begin
                            r_out <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
                            r_cnt  <= w_load;
                        end
                    end else if (w_expire) begin
                        r_out  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                OFF_DELAY: begin
                    if (w_level) begin
                        r_out  <= 1'b1;
                        r_busy <= 1'b0;
                        r_cnt  <= '0;
                    end else if (w_fall) begin
                        if (w_wb_zero) begin
                            r_out <= 1'b0;
                        end else begin
                            r_busy <= 1'b1;
                            r_cnt  <= w_load;
                        end
                    end else if (w_expire) begin
                        r_out  <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_out  <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_delay_timer.sv
// Self-checking bench for prog_delay_timer: directed scenarios plus randomized traffic,
// compared against a deadline-based reference model (honours TRIG_SYNC_EN when defined).
module tb_prog_delay_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] Wb;
    logic         mode_a;
    logic         mode_b;
    logic         trigger;
    logic         delay_out;

    int checks = 0;
    int errors = 0;

    // reference model state: absolute edge index and deadline edge of the pending event
    int   n    = 0;
    logic m_out = 1'b0;
    int   m_dl  = -1;
    logic m_tq  = 1'b0;
    logic [1:0] m_mode = 2'b00;
`ifdef TRIG_SYNC_EN
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
`endif

    int acc_h;
    int acc_mm;

    prog_delay_timer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Wb        (Wb),
        .mode_a    (mode_a),
        .mode_b    (mode_b),
        .trigger   (trigger),
        .delay_out (delay_out)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic t, rise, fall, expire;
        logic [1:0] md;
        int wb;
        md = {mode_a, mode_b};
        wb = int'(Wb);
        if (reset) begin
            m_out = 1'b0; m_dl = -1; m_tq = 1'b0; m_mode = md;
`ifdef TRIG_SYNC_EN
            m_s1 = 1'b0; m_s2 = 1'b0;
`endif
            return;
        end
`ifdef TRIG_SYNC_EN
        t = m_s2; m_s2 = m_s1; m_s1 = trigger;
`else
        t = trigger;
`endif
        rise = t & ~m_tq;
        fall = ~t & m_tq;
        m_tq = t;
        if (md != m_mode) begin
            m_mode = md; m_out = 1'b0; m_dl = -1;
            return;
        end
        expire = (m_dl == n);
        case (md)
            2'b00: begin
                if (m_dl >= n) begin
                    if (expire) begin m_out = 1'b0; m_dl = -1; end
                end else if (rise && wb != 0) begin
                    m_out = 1'b1; m_dl = n + wb;
                end
            end
            2'b01: begin
                if (rise) begin
                    if (wb != 0) begin m_out = 1'b1; m_dl = n + wb; end
                    else begin m_out = 1'b0; m_dl = -1; end
                end else if (expire) begin
                    m_out = 1'b0; m_dl = -1;
                end
            end
            2'b10: begin
                if (fall) begin m_out = 1'b0; m_dl = -1; end
                else if (rise) begin
                    if (wb == 0) m_out = 1'b1;
                    else m_dl = n + wb;
                end else if (expire) begin
                    m_out = 1'b1; m_dl = -1;
                end
            end
            default: begin
                if (t) begin m_out = 1'b1; m_dl = -1; end
                else if (fall) begin
                    if (wb == 0) m_out = 1'b0;
                    else m_dl = n + wb;
                end else if (expire) begin
                    m_out = 1'b0; m_dl = -1;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        n++;
        #1;
    endtask

    // holds trigger for cyc edges, tallying DUT high cycles and disagreements with the model
    task automatic drive(input logic t, input int cyc);
        trigger = t;
        repeat (cyc) begin
            tick();
            if (delay_out === 1'b1) acc_h++;
            if (delay_out !== m_out) acc_mm++;
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        {mode_a, mode_b} = m;
    endtask

    task automatic test_reset();
        reset = 1'b1; trigger = 1'b0; Wb = '0; set_mode(2'b00);
        tick();
        checks++;
        if (delay_out !== 1'b0) begin errors++; $display("FAIL reset_cycle1: delay_out=%b required 0", delay_out); end
        tick();
        checks++;
        if (delay_out !== 1'b0) begin errors++; $display("FAIL reset_cycle2: delay_out=%b required 0", delay_out); end
        reset = 1'b0;
        acc_h = 0; acc_mm = 0;
        drive(1'b0, 10);
        checks++;
        if (acc_h !== 0) begin errors++; $display("FAIL reset_idle: high cycles=%0d required 0", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL reset_idle_model: mismatches=%0d required 0", acc_mm); end
    endtask

    task automatic test_one_shot();
        set_mode(2'b00); Wb = 8'd3;
        drive(1'b0, 3);
        acc_h = 0; acc_mm = 0;
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 10);
        checks++;
        if (acc_h !== 3) begin errors++; $display("FAIL one_shot_width: high cycles=%0d required 3", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL one_shot_model: mismatches=%0d required 0", acc_mm); end
    endtask

    task automatic test_retrig();
        set_mode(2'b01); Wb = 8'd4;
        drive(1'b0, 3);
        acc_h = 0; acc_mm = 0;
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 1);
        drive(1'b1, 1); drive(1'b0, 12);
        checks++;
        if (acc_h !== 8) begin errors++; $display("FAIL retrig_width: high cycles=%0d required 8", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL retrig_model: mismatches=%0d required 0", acc_mm); end
    endtask

    task automatic test_on_delay();
        set_mode(2'b10); Wb = 8'd2;
        drive(1'b0, 3);
        acc_h = 0; acc_mm = 0;
        drive(1'b1, 4); drive(1'b0, 6);
        checks++;
        if (acc_h !== 2) begin errors++; $display("FAIL on_delay_width: high cycles=%0d required 2", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL on_delay_model: mismatches=%0d required 0", acc_mm); end
        acc_h = 0; acc_mm = 0;
        drive(1'b1, 1); drive(1'b0, 6);
        checks++;
        if (acc_h !== 0) begin errors++; $display("FAIL on_delay_short: high cycles=%0d required 0", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL on_delay_short_model: mismatches=%0d required 0", acc_mm); end
    endtask

    task automatic test_off_delay();
        set_mode(2'b11); Wb = 8'd3;
        drive(1'b0, 3);
        acc_h = 0; acc_mm = 0;
        drive(1'b1, 2); drive(1'b0, 8);
        checks++;
        if (acc_h !== 5) begin errors++; $display("FAIL off_delay_width: high cycles=%0d required 5", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL off_delay_model: mismatches=%0d required 0", acc_mm); end
        Wb = '0;
        acc_h = 0; acc_mm = 0;
        drive(1'b1, 2); drive(1'b0, 4);
        checks++;
        if (acc_h !== 2) begin errors++; $display("FAIL off_delay_wb0: high cycles=%0d required 2", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL off_delay_wb0_model: mismatches=%0d required 0", acc_mm); end
    endtask

    task automatic test_mode_switch();
        set_mode(2'b00); Wb = 8'd5;
        drive(1'b0, 3);
        acc_h = 0; acc_mm = 0;
        drive(1'b1, 1); drive(1'b0, 3);
        checks++;
        if (delay_out !== 1'b1) begin errors++; $display("FAIL switch_pulse_on: delay_out=%b required 1", delay_out); end
        set_mode(2'b10);
        drive(1'b0, 1);
        checks++;
        if (delay_out !== 1'b0) begin errors++; $display("FAIL switch_clear: delay_out=%b required 0", delay_out); end
        drive(1'b0, 8);
        set_mode(2'b00);
        drive(1'b0, 3);
        drive(1'b1, 1); drive(1'b0, 3);
        checks++;
        if (delay_out !== 1'b1) begin errors++; $display("FAIL reset_mid_on: delay_out=%b required 1", delay_out); end
        reset = 1'b1;
        drive(1'b0, 1);
        checks++;
        if (delay_out !== 1'b0) begin errors++; $display("FAIL reset_mid_clear: delay_out=%b required 0", delay_out); end
        reset = 1'b0;
        acc_h = 0;
        drive(1'b0, 10);
        checks++;
        if (acc_h !== 0) begin errors++; $display("FAIL reset_mid_idle: high cycles=%0d required 0", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL switch_model: mismatches=%0d required 0", acc_mm); end
    endtask

    task automatic test_max_delay();
        set_mode(2'b00); Wb = 8'd255;
        drive(1'b0, 3);
        acc_h = 0; acc_mm = 0;
        drive(1'b1, 1);
        Wb = 8'd2;
        drive(1'b0, 270);
        checks++;
        if (acc_h !== 255) begin errors++; $display("FAIL max_delay_width: high cycles=%0d required 255", acc_h); end
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL max_delay_model: mismatches=%0d required 0", acc_mm); end
    endtask

    task automatic test_random();
        logic t;
        t = 1'b0;
        acc_h = 0; acc_mm = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) set_mode(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) Wb = W'($urandom_range(0, 7));
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 2) == 0) t = ~t;
            drive(t, 1);
        end
        reset = 1'b0;
        checks++;
        if (acc_mm !== 0) begin errors++; $display("FAIL random_model: mismatches=%0d required 0", acc_mm); end
        checks++;
        if (acc_h == 0) begin errors++; $display("FAIL random_activity: high cycles=%0d required nonzero", acc_h); end
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; Wb = '0; mode_a = 1'b0; mode_b = 1'b0;
        test_reset();
        test_one_shot();
        test_retrig();
        test_on_delay();
        test_off_delay();
        test_mode_switch();
        test_max_delay();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
